// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for the sequential floating-point multiplier.
interface fp_mul_if #(
    parameter int unsigned EXP_BITS  = 8,
    parameter int unsigned FRAC_BITS = 23
);
    localparam int unsigned W = 1 + EXP_BITS + FRAC_BITS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_seq_multiplier.sv
// Sequential shift-add floating-point multiplier, round-to-nearest-even, no subnormals.
module fp_seq_multiplier #(
    parameter int unsigned EXP_BITS  = 8,
    parameter int unsigned FRAC_BITS = 23
) (
    input  logic    clk,
    input  logic    rst_n,
    fp_mul_if.slave bus
);
    localparam int unsigned W    = 1 + EXP_BITS + FRAC_BITS;
    localparam int unsigned M    = FRAC_BITS + 1;
    localparam int unsigned PW   = 2 * M;
    localparam int unsigned XW   = EXP_BITS + 2;
    localparam int unsigned CW   = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned BIAS = (2 ** (EXP_BITS - 1)) - 1;
    localparam logic signed [XW-1:0]   EMAX     = XW'((2 ** EXP_BITS) - 1);
    localparam logic [EXP_BITS-1:0]    EXP_ONES = '1;
    localparam logic [FRAC_BITS-1:0]   FRAC_QNAN = FRAC_BITS'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [PW-1:0]  prod_q;
    logic [CW-1:0]  cnt_q;

    logic           accept_c;
    logic           special_c;
    logic [W-1:0]   spec_res_c;
    logic [3:0]     spec_flags_c;
    logic [W-1:0]   norm_res_c;
    logic [3:0]     norm_flags_c;
    logic [M-1:0]   ma_c, mb_c;

    assign accept_c = bus.in_valid && bus.in_ready;
    assign ma_c     = {1'b1, a_q[FRAC_BITS-1:0]};
    assign mb_c     = {1'b1, b_q[FRAC_BITS-1:0]};

    // Operand classification on the live inputs; only used on the accept edge.
    logic [EXP_BITS-1:0] ea_in, eb_in;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, s_in;
    always_comb begin
        ea_in  = bus.a[W-2 -: EXP_BITS];
        eb_in  = bus.b[W-2 -: EXP_BITS];
        s_in   = bus.a[W-1] ^ bus.b[W-1];
        a_zero = (ea_in == '0);
        b_zero = (eb_in == '0);
        a_inf  = (ea_in == EXP_ONES) && (bus.a[FRAC_BITS-1:0] == '0);
        b_inf  = (eb_in == EXP_ONES) && (bus.b[FRAC_BITS-1:0] == '0);
        a_nan  = (ea_in == EXP_ONES) && (bus.a[FRAC_BITS-1:0] != '0);
        b_nan  = (eb_in == EXP_ONES) && (bus.b[FRAC_BITS-1:0] != '0);
        special_c    = a_zero || b_zero || a_inf || b_inf || a_nan || b_nan;
        spec_res_c   = {s_in, {(W-1){1'b0}}};
        spec_flags_c = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res_c = {1'b0, EXP_ONES, FRAC_QNAN};
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_res_c   = {1'b0, EXP_ONES, FRAC_QNAN};
            spec_flags_c = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res_c = {s_in, EXP_ONES, {FRAC_BITS{1'b0}}};
        end
    end

    // Normalise, round to nearest even, and saturate to inf / flush to zero.
    logic [PW-1:0]          sh;
    logic [M-1:0]           mant;
    logic [M:0]             mant_r;
    logic                   guard, sticky, rnd_up, sign_c;
    logic signed [XW-1:0]   exp_c, exp_f;
    logic [FRAC_BITS-1:0]   frac_f;
    always_comb begin
        sign_c = a_q[W-1] ^ b_q[W-1];
        sh     = prod_q[PW-1] ? prod_q : (prod_q << 1);
        mant   = sh[PW-1 -: M];
        guard  = sh[M-1];
        sticky = |sh[M-2:0];
        rnd_up = guard && (sticky || mant[0]);
        mant_r = {1'b0, mant} + (M+1)'(rnd_up);
        exp_c  = XW'(a_q[W-2 -: EXP_BITS]) + XW'(b_q[W-2 -: EXP_BITS])
               - XW'(BIAS) + XW'(prod_q[PW-1]);
        exp_f  = exp_c + XW'(mant_r[M]);
        frac_f = mant_r[M] ? mant_r[M-1:1] : mant_r[FRAC_BITS-1:0];
        norm_res_c   = {sign_c, exp_f[EXP_BITS-1:0], frac_f};
        norm_flags_c = {3'b000, guard || sticky};
        if (exp_f >= EMAX) begin
            norm_res_c   = {sign_c, EXP_ONES, {FRAC_BITS{1'b0}}};
            norm_flags_c = 4'b0101;
        end else if (exp_f[XW-1] || (exp_f == '0)) begin
            norm_res_c   = {sign_c, {(W-1){1'b0}}};
            norm_flags_c = 4'b0011;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = special_c ? DONE : MULT;
            MULT: if (cnt_q == CW'(FRAC_BITS)) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.flags     <= '0;
            a_q           <= '0;
            b_q           <= '0;
            prod_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus.in_ready  <= (state_d == IDLE);
            bus.out_valid <= (state_d == DONE);
            case (state_q)
                IDLE: if (accept_c) begin
                    a_q    <= bus.a;
                    b_q    <= bus.b;
                    prod_q <= '0;
                    cnt_q  <= '0;
                    if (special_c) begin
                        bus.result <= spec_res_c;
                        bus.flags  <= spec_flags_c;
                    end
                end
                // One multiplier bit per cycle, LSB first.
                MULT: begin
                    if (mb_c[cnt_q]) prod_q <= prod_q + (PW'(ma_c) << cnt_q);
                    cnt_q <= cnt_q + CW'(1);
                end
                NORM: begin
                    bus.result <= norm_res_c;
                    bus.flags  <= norm_flags_c;
                end
                default: ;
            endcase
        end
    end
endmodule
